alu_instruction_sequencer: RTL and testbench
============================================

Name: alu_instruction_sequencer

Overview:
Multi-cycle fetch/execute controller driving the ALU instruction decoder. Owns the program counter and the instruction register, and fetches 16-bit instructions over a req/ack port. It presents the instruction to the decoder, then sequences register writeback and memory/stack stores using the decoder's control outputs. Sits between instruction memory, the decoder, the register file and the memory/stack ports.

Parameters:
PC_WIDTH, 16, program counter / instruction address width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
imem_req  out  1  instruction fetch request, held until imem_ack
imem_addr  out  PC_WIDTH  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_data valid this cycle
imem_data  in  16  fetched instruction
instr  out  16  instruction register, feeds decoder
dec_pc_inc  in  1  decoder program_counter_increment
dec_load_src  in  2  decoder alu_load_src
dec_store_mem  in  1  decoder alu_store_to_mem
dec_store_stk  in  1  decoder alu_store_to_stk
alu_result  in  16  ALU output; jump target when dec_pc_inc=0
reg_we  out  1  register-file write strobe (single cycle)
mem_req  out  1  memory store/load request, held until mem_ack
mem_ack  in  1  memory access complete
stk_req  out  1  stack push request, held until stk_ack
stk_ack  in  1  stack push complete
halt_req  in  1  pause after current instruction retires
halted  out  1  high while in HALT
pc  out  PC_WIDTH  current program counter

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous, active-high. While rst is high at an edge: state=FETCH, pc=RESET_PC, instr=16'h0000; imem_req, mem_req, stk_req, reg_we and halted are all 0 the cycle after. Reset mid-transaction drops any request immediately; a pending ack is ignored.
- States: FETCH, EXEC, MEM, STK, HALT.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_data, go EXEC. Minimum fetch latency is 1 cycle; ack in the first request cycle is legal.
- EXEC (exactly 1 cycle; decoder inputs sampled combinationally from instr):
  - dec_load_src=01: reg_we=1 this cycle.
  - If dec_store_mem=1 or dec_load_src=10: go MEM.
  - Else if dec_store_stk=1: go STK.
  - Else retire.
  - dec_load_src 00/11: no writeback.
- MEM:
  - mem_req=1 until mem_ack.
  - On mem_ack: reg_we=1 that same cycle if dec_load_src=10 and dec_store_mem=0. If both are set, the store wins and there is no writeback.
  - Then go STK if dec_store_stk, else retire.
- STK: stk_req=1 until stk_ack, then retire.
- Retire (last cycle of an instruction):
  - pc <= dec_pc_inc ? pc+1 : alu_result[PC_WIDTH-1:0]. pc+1 wraps modulo 2^PC_WIDTH.
  - Next state is HALT if halt_req=1 at that edge, else FETCH.
- HALT:
  - halted=1, no requests.
  - Returns to FETCH on the first edge with halt_req=0; pc is unchanged.
  - halt_req asserted mid-instruction takes effect only at retire.
- At most one of imem_req, mem_req and stk_req is high in any cycle.
- instr is stable from EXEC through retire.

Optional Feature:
ALU_SEQ_ERROR_HALT_EN
- Defined: adds input alu_error (1 bit, decoder errorbit OR-reduced).
  - alu_error=1 in EXEC suppresses reg_we, MEM and STK.
  - pc is held, not advanced, and the sequencer enters HALT with sticky output err_halt=1.
  - Only rst clears err_halt and leaves that HALT; halt_req is ignored there.
- Undefined: no alu_error or err_halt ports; errors have no effect on sequencing.

Decomposition:
- Shared package alu_seq_pkg:
  - state encoding constants: FETCH=0, EXEC=1, MEM=2, STK=3, HALT=4 (3-bit).
  - load-source constants: LOAD_NONE=00, LOAD_REG=01, LOAD_MEM=10.
  - RESET_PC default.
- One natural sub-module, program_counter: holds pc, with inputs rst, load, inc/jump select and target. Handles wrap and RESET_PC.

Test Plan:
- Reset then sequential ops: imem_data=16'h3123 with dec_load_src=01, dec_pc_inc=1, ack in 1 cycle -> reg_we pulses once in EXEC; pc goes 0->1; 3 cycles per instruction.
- Jump: dec_pc_inc=0, alu_result=16'h0040 -> next imem_addr=16'h0040; no reg_we when dec_load_src=00.
- Store to memory and stack: dec_store_mem=1, dec_store_stk=1, mem_ack delayed 3 cycles, stk_ack delayed 2 cycles -> mem_req held 3 cycles, then stk_req 2 cycles, never overlapping; pc advances only after stk_ack.
- Wrap and halt: pc=16'hFFFF, dec_pc_inc=1, halt_req=1 during EXEC -> pc=0, halted=1 with no requests; drop halt_req -> FETCH at addr 0 next cycle.
- Reset mid-MEM: rst asserted while mem_req=1 -> mem_req=0 next cycle, pc=RESET_PC, state FETCH; a stale mem_ack is ignored.
- ALU_SEQ_ERROR_HALT_EN: alu_error=1 in EXEC with dec_load_src=01 -> no reg_we, pc held, err_halt=1; halt_req toggling has no effect; rst clears it.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared constants for the ALU instruction sequencer:
//   - FSM state encoding (3-bit): FETCH, EXEC, MEM, STK, HALT
//   - decoder load-source encodings: LOAD_NONE, LOAD_REG, LOAD_MEM
//   - default reset value of the program counter
//   - needs_mem(): whether an instruction has a memory phase
package alu_seq_pkg;

  localparam logic [2:0] FETCH = 3'd0;
  localparam logic [2:0] EXEC  = 3'd1;
  localparam logic [2:0] MEM   = 3'd2;
  localparam logic [2:0] STK   = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;

  localparam logic [1:0] LOAD_NONE = 2'b00;
  localparam logic [1:0] LOAD_REG  = 2'b01;
  localparam logic [1:0] LOAD_MEM  = 2'b10;

  localparam int unsigned RESET_PC_DEFAULT = 0;

  // A store to memory or a load from memory both go through the MEM phase.
  function automatic logic needs_mem(input logic store_mem, input logic [1:0] load_src);
    return store_mem || (load_src == LOAD_MEM);
  endfunction

endpackage

// File: rtl/alu_instruction_sequencer_program_counter.sv
// program_counter
// Holds the program counter for the ALU instruction sequencer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (loads RESET_PC)
//   load_i     : update pc this edge (instruction retire)
//   jump_i     : 1 = take target_i, 0 = increment (wraps modulo 2^PC_WIDTH)
//   target_i   : jump target
//   pc_o       : current program counter
module program_counter
  import alu_seq_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                jump_i,
  input  logic [PC_WIDTH-1:0] target_i,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  // Increment naturally wraps at the register width.
  assign pc_d = jump_i ? target_i : (pc_q + PC_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/alu_instruction_sequencer.sv
// alu_instruction_sequencer
// Multi-cycle fetch/execute controller in front of the ALU instruction
// decoder. Fetches 16-bit instructions, holds them in the instruction
// register, and sequences register writeback plus memory / stack accesses.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   imem_req/addr/ack/data  : instruction fetch port
//   instr                   : instruction register, drives the decoder
//   dec_pc_inc, dec_load_src, dec_store_mem, dec_store_stk : decoder controls
//   alu_result              : ALU output, used as jump target
//   reg_we                  : register-file write strobe (one cycle)
//   mem_req/mem_ack         : memory access port
//   stk_req/stk_ack         : stack push port
//   halt_req / halted       : pause after retire / in HALT
//   dbg_state               : current FSM state (alu_seq_pkg encoding)
//   pc                      : program counter
// Optional build macro ALU_SEQ_ERROR_HALT_EN adds:
//   alu_error (in)          : decoder error; in EXEC it aborts the instruction
//   err_halt  (out)         : sticky, set on an error halt, cleared only by rst
//
// Handshakes: every *_req is a level held high from the first request cycle
// through the cycle its *_ack is seen high; the transfer completes in that
// ack cycle and the request drops on the following cycle. Acks outside a
// request are ignored. Requests are mutually exclusive because each is owned
// by exactly one FSM state.
module alu_instruction_sequencer
  import alu_seq_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic [15:0]         instr,
  input  logic                dec_pc_inc,
  input  logic [1:0]          dec_load_src,
  input  logic                dec_store_mem,
  input  logic                dec_store_stk,
  input  logic [15:0]         alu_result,
  output logic                reg_we,
  output logic                mem_req,
  input  logic                mem_ack,
  output logic                stk_req,
  input  logic                stk_ack,
  input  logic                halt_req,
  output logic                halted,
  output logic [2:0]          dbg_state,
  output logic [PC_WIDTH-1:0] pc
`ifdef ALU_SEQ_ERROR_HALT_EN
  ,
  input  logic                alu_error,
  output logic                err_halt
`endif
);

  logic [2:0]  state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        retire;
  logic        reg_we_c;
  logic        exec_err;
  logic        err_hold;

`ifdef ALU_SEQ_ERROR_HALT_EN
  logic err_halt_q, err_halt_d;

  assign exec_err   = (state_q == EXEC) && alu_error;
  assign err_halt_d = err_halt_q || exec_err;
  assign err_hold   = err_halt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_halt_q <= 1'b0;
    end else begin
      err_halt_q <= err_halt_d;
    end
  end

  assign err_halt = err_halt_q;
`else
  assign exec_err = 1'b0;
  assign err_hold = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    retire   = 1'b0;
    reg_we_c = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (exec_err) begin
          // Aborted instruction: no writeback, no accesses, pc not loaded.
          state_d = HALT;
        end else begin
          reg_we_c = (dec_load_src == LOAD_REG);
          if (needs_mem(dec_store_mem, dec_load_src)) begin
            state_d = MEM;
          end else if (dec_store_stk) begin
            state_d = STK;
          end else begin
            retire = 1'b1;
          end
        end
      end
      MEM: begin
        if (mem_ack) begin
          // A store takes precedence over a memory load: no writeback then.
          reg_we_c = (dec_load_src == LOAD_MEM) && !dec_store_mem;
          if (dec_store_stk) begin
            state_d = STK;
          end else begin
            retire = 1'b1;
          end
        end
      end
      STK: begin
        if (stk_ack) begin
          retire = 1'b1;
        end
      end
      HALT: begin
        // An error halt is left only through reset.
        if (!err_hold && !halt_req) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    if (retire) begin
      state_d = halt_req ? HALT : FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  program_counter #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load_i   (retire),
    .jump_i   (!dec_pc_inc),
    .target_i (alu_result[PC_WIDTH-1:0]),
    .pc_o     (pc)
  );

  // Strobes are masked by rst so an in-flight request drops at once.
  assign imem_req  = !rst && (state_q == FETCH);
  assign mem_req   = !rst && (state_q == MEM);
  assign stk_req   = !rst && (state_q == STK);
  assign halted    = !rst && (state_q == HALT);
  assign reg_we    = !rst && reg_we_c;
  assign imem_addr = pc;
  assign instr     = instr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_instruction_sequencer.sv
module tb_alu_instruction_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] instr;
  logic        dec_pc_inc = 1'b1;
  logic [1:0]  dec_load_src = 2'b00;
  logic        dec_store_mem = 1'b0;
  logic        dec_store_stk = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic        reg_we;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic        stk_req;
  logic        stk_ack = 1'b0;
  logic        halt_req = 1'b0;
  logic        halted;
  logic [2:0]  dbg_state;
  logic [15:0] pc;
`ifdef ALU_SEQ_ERROR_HALT_EN
  logic        alu_error = 1'b0;
  logic        err_halt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_instruction_sequencer #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .instr         (instr),
    .dec_pc_inc    (dec_pc_inc),
    .dec_load_src  (dec_load_src),
    .dec_store_mem (dec_store_mem),
    .dec_store_stk (dec_store_stk),
    .alu_result    (alu_result),
    .reg_we        (reg_we),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .stk_req       (stk_req),
    .stk_ack       (stk_ack),
    .halt_req      (halt_req),
    .halted        (halted),
    .dbg_state     (dbg_state),
    .pc            (pc)
`ifdef ALU_SEQ_ERROR_HALT_EN
    ,
    .alu_error     (alu_error),
    .err_halt      (err_halt)
`endif
  );

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({imem_req, mem_req, stk_req, reg_we, halted} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_strobes got=%b exp=00000", {imem_req, mem_req, stk_req, reg_we, halted});
    end
    checks++;
    if (pc !== 16'h0000 || instr !== 16'h0000 || dbg_state !== FETCH) begin
      failures++;
      $display("FAIL reset_state pc=%h instr=%h state=%0d exp pc=0000 instr=0000 state=0", pc, instr, dbg_state);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      failures++;
      $display("FAIL reset_first_fetch req=%b addr=%h exp req=1 addr=0000", imem_req, imem_addr);
    end
  endtask

  // Two register-writing instructions, fetch ack one cycle after request.
  task automatic test_sequential;
    int we_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); imem_ack = 1'b0; dec_load_src = 2'b01; dec_pc_inc = 1'b1; #1;
      we_cnt += int'(reg_we);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'(i)) begin
        failures++;
        $display("FAIL seq_fetch%0d req=%b addr=%h exp req=1 addr=%h", i, imem_req, imem_addr, 16'(i));
      end
      @(negedge clk); imem_ack = 1'b1; imem_data = 16'h3123; #1;
      we_cnt += int'(reg_we);
      @(negedge clk); imem_ack = 1'b0; #1;
      we_cnt += int'(reg_we);
      checks++;
      if (dbg_state !== EXEC || instr !== 16'h3123 || reg_we !== 1'b1 || imem_req !== 1'b0) begin
        failures++;
        $display("FAIL seq_exec%0d state=%0d instr=%h we=%b ireq=%b exp state=1 instr=3123 we=1 ireq=0",
                 i, dbg_state, instr, reg_we, imem_req);
      end
    end
    @(negedge clk); #1;
    we_cnt += int'(reg_we);
    checks++;
    if (pc !== 16'h0002 || we_cnt != 2 || dbg_state !== FETCH) begin
      failures++;
      $display("FAIL seq_end pc=%h we_pulses=%0d state=%0d exp pc=0002 we_pulses=2 state=0", pc, we_cnt, dbg_state);
    end
  endtask

  task automatic test_jump;
    @(negedge clk); imem_ack = 1'b1; imem_data = 16'hC040; dec_load_src = 2'b00;
    dec_pc_inc = 1'b0; alu_result = 16'h0040; #1;
    @(negedge clk); imem_ack = 1'b0; #1;
    checks++;
    if (reg_we !== 1'b0 || dbg_state !== EXEC) begin
      failures++;
      $display("FAIL jump_exec we=%b state=%0d exp we=0 state=1", reg_we, dbg_state);
    end
    @(negedge clk); dec_pc_inc = 1'b1; #1;
    checks++;
    if (imem_addr !== 16'h0040 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL jump_target addr=%h req=%b exp addr=0040 req=1", imem_addr, imem_req);
    end
  endtask

  // Store to mem and stack with delayed acks, then a plain memory load.
  task automatic test_store_mem_stk;
    @(negedge clk); imem_ack = 1'b1; imem_data = 16'h8A55; dec_pc_inc = 1'b1;
    dec_load_src = 2'b10; dec_store_mem = 1'b1; dec_store_stk = 1'b1; #1;
    @(negedge clk); imem_ack = 1'b0; #1;
    checks++;
    if ({imem_req, mem_req, stk_req, reg_we} !== 4'b0000 || dbg_state !== EXEC) begin
      failures++;
      $display("FAIL store_exec strobes=%b state=%0d exp strobes=0000 state=1",
               {imem_req, mem_req, stk_req, reg_we}, dbg_state);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); mem_ack = (k == 2); #1;
      checks++;
      if ({imem_req, mem_req, stk_req, reg_we} !== 4'b0100 || pc !== 16'h0040) begin
        failures++;
        $display("FAIL store_mem%0d strobes=%b pc=%h exp strobes=0100 pc=0040",
                 k, {imem_req, mem_req, stk_req, reg_we}, pc);
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); mem_ack = 1'b0; stk_ack = (k == 1); #1;
      checks++;
      if ({imem_req, mem_req, stk_req, reg_we} !== 4'b0010 || pc !== 16'h0040) begin
        failures++;
        $display("FAIL store_stk%0d strobes=%b pc=%h exp strobes=0010 pc=0040",
                 k, {imem_req, mem_req, stk_req, reg_we}, pc);
      end
    end
    @(negedge clk); stk_ack = 1'b0; #1;
    checks++;
    if (pc !== 16'h0041 || imem_req !== 1'b1 || stk_req !== 1'b0) begin
      failures++;
      $display("FAIL store_retire pc=%h ireq=%b sreq=%b exp pc=0041 ireq=1 sreq=0", pc, imem_req, stk_req);
    end
    // Memory load: writeback happens in the mem_ack cycle.
    @(negedge clk); imem_ack = 1'b1; dec_store_mem = 1'b0; dec_store_stk = 1'b0; dec_load_src = 2'b10; #1;
    @(negedge clk); imem_ack = 1'b0; #1;
    checks++;
    if (reg_we !== 1'b0) begin
      failures++;
      $display("FAIL load_exec_we got=%b exp=0", reg_we);
    end
    @(negedge clk); mem_ack = 1'b1; #1;
    checks++;
    if (reg_we !== 1'b1 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL load_mem_we we=%b mreq=%b exp we=1 mreq=1", reg_we, mem_req);
    end
    @(negedge clk); mem_ack = 1'b0; dec_load_src = 2'b00; #1;
    checks++;
    if (pc !== 16'h0042 || reg_we !== 1'b0 || dbg_state !== FETCH) begin
      failures++;
      $display("FAIL load_retire pc=%h we=%b state=%0d exp pc=0042 we=0 state=0", pc, reg_we, dbg_state);
    end
  endtask

  task automatic test_wrap_halt;
    @(negedge clk); imem_ack = 1'b1; dec_load_src = 2'b00; dec_pc_inc = 1'b0; alu_result = 16'hFFFF; #1;
    @(negedge clk); imem_ack = 1'b0; #1;
    @(negedge clk); dec_pc_inc = 1'b1; #1;
    checks++;
    if (pc !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_setup pc=%h exp=ffff", pc);
    end
    @(negedge clk); imem_ack = 1'b1; #1;
    @(negedge clk); imem_ack = 1'b0; halt_req = 1'b1; #1;
    @(negedge clk); #1;
    checks++;
    if (halted !== 1'b1 || pc !== 16'h0000 || {imem_req, mem_req, stk_req} !== 3'b000) begin
      failures++;
      $display("FAIL wrap_halt halted=%b pc=%h reqs=%b exp halted=1 pc=0000 reqs=000",
               halted, pc, {imem_req, mem_req, stk_req});
    end
    @(negedge clk); halt_req = 1'b0; #1;
    checks++;
    if (halted !== 1'b1 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL halt_hold halted=%b ireq=%b exp halted=1 ireq=0", halted, imem_req);
    end
    @(negedge clk); #1;
    checks++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      failures++;
      $display("FAIL halt_resume halted=%b ireq=%b addr=%h exp halted=0 ireq=1 addr=0000", halted, imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_mem;
    // Move pc away from the reset value first.
    @(negedge clk); imem_ack = 1'b1; dec_pc_inc = 1'b0; alu_result = 16'h0123; #1;
    @(negedge clk); imem_ack = 1'b0; #1;
    @(negedge clk); imem_ack = 1'b1; dec_pc_inc = 1'b1; dec_store_mem = 1'b1; imem_data = 16'h5A5A; #1;
    checks++;
    if (imem_addr !== 16'h0123) begin
      failures++;
      $display("FAIL rstmem_setup addr=%h exp=0123", imem_addr);
    end
    @(negedge clk); imem_ack = 1'b0; #1;
    @(negedge clk); #1;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rstmem_req got=%b exp=1", mem_req);
    end
    @(negedge clk); rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; mem_ack = 1'b1; #1;
    checks++;
    if (mem_req !== 1'b0 || pc !== 16'h0000 || dbg_state !== FETCH || instr !== 16'h0000 || reg_we !== 1'b0) begin
      failures++;
      $display("FAIL rstmem_after mreq=%b pc=%h state=%0d instr=%h we=%b exp mreq=0 pc=0000 state=0 instr=0000 we=0",
               mem_req, pc, dbg_state, instr, reg_we);
    end
    @(negedge clk); mem_ack = 1'b0; dec_store_mem = 1'b0; #1;
    checks++;
    if (dbg_state !== FETCH || imem_req !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL rstmem_stale_ack state=%0d ireq=%b mreq=%b exp state=0 ireq=1 mreq=0", dbg_state, imem_req, mem_req);
    end
  endtask

`ifdef ALU_SEQ_ERROR_HALT_EN
  task automatic test_error_halt;
    @(negedge clk); imem_ack = 1'b1; dec_load_src = 2'b01; dec_pc_inc = 1'b1; #1;
    @(negedge clk); imem_ack = 1'b0; alu_error = 1'b1; #1;
    checks++;
    if (reg_we !== 1'b0) begin
      failures++;
      $display("FAIL err_we got=%b exp=0", reg_we);
    end
    @(negedge clk); alu_error = 1'b0; #1;
    checks++;
    if (halted !== 1'b1 || err_halt !== 1'b1 || pc !== 16'h0000) begin
      failures++;
      $display("FAIL err_halt halted=%b err=%b pc=%h exp halted=1 err=1 pc=0000", halted, err_halt, pc);
    end
    @(negedge clk); halt_req = 1'b1; #1;
    @(negedge clk); halt_req = 1'b0; #1;
    @(negedge clk); #1;
    checks++;
    if (halted !== 1'b1 || err_halt !== 1'b1 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL err_sticky halted=%b err=%b ireq=%b exp halted=1 err=1 ireq=0", halted, err_halt, imem_req);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; dec_load_src = 2'b00; #1;
    checks++;
    if (err_halt !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1) begin
      failures++;
      $display("FAIL err_clear err=%b halted=%b ireq=%b exp err=0 halted=0 ireq=1", err_halt, halted, imem_req);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_store_mem_stk();
    test_wrap_halt();
    test_reset_mid_mem();
`ifdef ALU_SEQ_ERROR_HALT_EN
    test_error_halt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
